// File: rtl/uart_cmd_responder.sv
// ASCII hex command parser and register file between uart_rx and uart_tx.
// Accepts "W a d1 d0 EOL" writes and "R a EOL" reads, and answers through uart_tx's start/busy handshake.
module uart_cmd_responder #(
  parameter logic [7:0] REG_INIT = 8'h00,
  parameter logic [7:0] EOL      = 8'h0D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rx_overrun
);

  typedef enum logic [2:0] {IDLE, W_A, W_D1, W_D0, W_EOL, R_A, R_EOL, FLUSH} pstate_t;
  typedef enum logic [1:0] {RIDLE, SEND, WAIT_HI, WAIT_LO} rstate_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39)      return {1'b1, 4'(b - 8'h30)};
    else if (b >= 8'h41 && b <= 8'h46) return {1'b1, 4'(b - 8'h37)};
    else if (b >= 8'h61 && b <= 8'h66) return {1'b1, 4'(b - 8'h57)};
    else                               return 5'b0_0000;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  pstate_t    pstate, pstate_nxt;
  rstate_t    rstate, rstate_nxt;
  logic [3:0] addr, hi, lo;
  logic [7:0] regs [16];
  logic [7:0] rbuf [4];
  logic [2:0] count, idx, idx_nxt;
  logic       hi_wait, hi_wait_nxt;
  logic       tx_start_nxt;
  logic [7:0] tx_data_nxt;
  logic       accept, is_eol, dig_ok, resp_done;
  logic [3:0] dig;
  logic       do_write, do_read, do_err, latch_a, latch_hi, latch_lo;

  // Bytes are only parsed while no reply is in flight; otherwise they are dropped.
  assign accept          = rx_done && (rstate == RIDLE);
  assign is_eol          = (rx_data == EOL);
  assign {dig_ok, dig}   = hex_decode(rx_data);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    pstate_nxt = pstate;
    do_write   = 1'b0;
    do_read    = 1'b0;
    do_err     = 1'b0;
    latch_a    = 1'b0;
    latch_hi   = 1'b0;
    latch_lo   = 1'b0;
    if (accept) begin
      case (pstate)
        IDLE: begin
          if (rx_data == 8'h57)                    pstate_nxt = W_A;
          else if (rx_data == 8'h52)               pstate_nxt = R_A;
          else if (!(is_eol || rx_data == LF))     pstate_nxt = FLUSH;
        end
        W_A, W_D1, W_D0, R_A: begin
          if (is_eol) begin
            do_err     = 1'b1;
            pstate_nxt = IDLE;
          end else if (!dig_ok) begin
            pstate_nxt = FLUSH;
          end else begin
            case (pstate)
              W_A:     begin latch_a  = 1'b1; pstate_nxt = W_D1;  end
              W_D1:    begin latch_hi = 1'b1; pstate_nxt = W_D0;  end
              W_D0:    begin latch_lo = 1'b1; pstate_nxt = W_EOL; end
              default: begin latch_a  = 1'b1; pstate_nxt = R_EOL; end
            endcase
          end
        end
        W_EOL: begin
          do_write   = is_eol;
          pstate_nxt = is_eol ? IDLE : FLUSH;
        end
        R_EOL: begin
          do_read    = is_eol;
          pstate_nxt = is_eol ? IDLE : FLUSH;
        end
        default: begin
          do_err     = is_eol;
          pstate_nxt = is_eol ? IDLE : FLUSH;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the register file is deliberately reset, since a defined REG_INIT after reset is architectural.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pstate     <= IDLE;
      addr       <= 4'h0;
      hi         <= 4'h0;
      lo         <= 4'h0;
      count      <= 3'd0;
      wr_en      <= 1'b0;
      wr_addr    <= 4'h0;
      wr_data    <= 8'h00;
      rx_overrun <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= REG_INIT;
      for (int i = 0; i < 4; i++)  rbuf[i] <= 8'h00;
    end else begin
      pstate     <= pstate_nxt;
      rx_overrun <= rx_done && (rstate != RIDLE);
      wr_en      <= do_write;
      if (latch_a)  addr <= dig;
      if (latch_hi) hi   <= dig;
      if (latch_lo) lo   <= dig;
      if (do_write) begin
        regs[addr] <= {hi, lo};
        wr_addr    <= addr;
        wr_data    <= {hi, lo};
        rbuf[0]    <= 8'h4B;
        rbuf[1]    <= CR;
        rbuf[2]    <= LF;
        count      <= 3'd3;
      end else if (do_read) begin
        rbuf[0]    <= hex_char(regs[addr][7:4]);
        rbuf[1]    <= hex_char(regs[addr][3:0]);
        rbuf[2]    <= CR;
        rbuf[3]    <= LF;
        count      <= 3'd4;
      end else if (do_err) begin
        rbuf[0]    <= 8'h45;
        rbuf[1]    <= CR;
        rbuf[2]    <= LF;
        count      <= 3'd3;
      end else if (resp_done) begin
        count      <= 3'd0;
      end
    end
  end

  // Responder: one tx_start per byte, then wait for busy to rise (or a 2-cycle timeout) and fall.
  always_comb begin
    rstate_nxt   = rstate;
    idx_nxt      = idx;
    hi_wait_nxt  = 1'b0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    resp_done    = 1'b0;
    case (rstate)
      RIDLE: begin
        if (count != 3'd0) begin
          rstate_nxt = SEND;
          idx_nxt    = 3'd0;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = rbuf[idx[1:0]];
          rstate_nxt   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy || hi_wait) rstate_nxt  = WAIT_LO;
        else                    hi_wait_nxt = 1'b1;
      end
      default: begin
        if (!tx_busy) begin
          if (3'(idx + 3'd1) == count) begin
            rstate_nxt = RIDLE;
            resp_done  = 1'b1;
          end else begin
            rstate_nxt = SEND;
            idx_nxt    = 3'(idx + 3'd1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate   <= RIDLE;
      idx      <= 3'd0;
      hi_wait  <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      rstate   <= rstate_nxt;
      idx      <= idx_nxt;
      hi_wait  <= hi_wait_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
    end
  end

endmodule
